// File: rtl/fft16_bfly_sequencer.sv
// Frame controller for a 16-point radix-2 DIT FFT built around one external,
// time-multiplexed butterfly: bit-reversed load, 4x8 in-place butterflies, natural-order unload.
module fft16_bfly_sequencer #(
   parameter int N = 16,
   parameter int Q = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [N-1:0] i_in_re,
   input  logic [N-1:0] i_in_im,
   output logic [N-1:0] o_bf_in0_re,
   output logic [N-1:0] o_bf_in0_im,
   output logic [N-1:0] o_bf_in1_re,
   output logic [N-1:0] o_bf_in1_im,
   output logic [N-1:0] o_bf_tw_re,
   output logic [N-1:0] o_bf_tw_im,
   input  logic [N-1:0] i_bf_out0_re,
   input  logic [N-1:0] i_bf_out0_im,
   input  logic [N-1:0] i_bf_out1_re,
   input  logic [N-1:0] i_bf_out1_im,
   input  logic         i_bf_done,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [N-1:0] o_out_re,
   output logic [N-1:0] o_out_im,
   output logic [3:0]   o_out_idx,
   output logic         o_busy,
   output logic         o_frame_done,
   output logic [2:0]   o_dbg_state
);

   // Valid/ready: a sample moves on a rising edge where valid and ready are both high;
   // the source holds data stable while valid is high and ready is low.

   typedef enum logic [2:0] {
      S_LOAD   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_WRITE  = 3'd3,
      S_UNLOAD = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [3:0]   cnt_q;
   logic [1:0]   s_q;
   logic [2:0]   b_q;
   logic         armed_q;
   logic         frame_done_q;

   logic [N-1:0] mem_re [16];
   logic [N-1:0] mem_im [16];

   logic [N-1:0] in0_re_q, in0_im_q, in1_re_q, in1_im_q, tw_re_q, tw_im_q;

   logic [3:0]   top_addr;
   logic [3:0]   bot_addr;
   logic [2:0]   tw_addr;
   logic [N-1:0] rom_re, rom_im;
   logic [3:0]   load_addr;

   logic         last_bfly;
   logic         in_fire;
   logic         out_fire;

   assign load_addr = {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]};
   assign last_bfly = (s_q == 2'd3) && (b_q == 3'd7);
   assign in_fire   = (state_q == S_LOAD) && i_in_valid;
   assign out_fire  = (state_q == S_UNLOAD) && i_out_ready;

   // top = b with a zero inserted at bit s; bot sets that bit; k = pos << (3-s).
   always_comb begin
      top_addr = 4'd0;
      tw_addr  = 3'd0;
      case (s_q)
         2'd0: begin
            top_addr = {b_q, 1'b0};
            tw_addr  = 3'd0;
         end
         2'd1: begin
            top_addr = {b_q[2:1], 1'b0, b_q[0]};
            tw_addr  = {b_q[0], 2'b00};
         end
         2'd2: begin
            top_addr = {b_q[2], 1'b0, b_q[1:0]};
            tw_addr  = {b_q[1:0], 1'b0};
         end
         default: begin
            top_addr = {1'b0, b_q};
            tw_addr  = b_q;
         end
      endcase
      bot_addr = top_addr | (4'd1 << s_q);
   end

   // Twiddle ROM: (cos(2*pi*k/16), -sin(2*pi*k/16)) scaled by 2^8.
   always_comb begin
      rom_re = '0;
      rom_im = '0;
      case (tw_addr)
         3'd0: begin rom_re = N'(256);  rom_im = N'(0);    end
         3'd1: begin rom_re = N'(237);  rom_im = N'(-98);  end
         3'd2: begin rom_re = N'(181);  rom_im = N'(-181); end
         3'd3: begin rom_re = N'(98);   rom_im = N'(-237); end
         3'd4: begin rom_re = N'(0);    rom_im = N'(-256); end
         3'd5: begin rom_re = N'(-98);  rom_im = N'(-237); end
         3'd6: begin rom_re = N'(-181); rom_im = N'(-181); end
         default: begin rom_re = N'(-237); rom_im = N'(-98); end
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:   if (i_in_valid && (cnt_q == 4'd15)) state_d = S_ISSUE;
         S_ISSUE:  state_d = S_WAIT;
         S_WAIT:   if (armed_q && i_bf_done) state_d = S_WRITE;
         S_WRITE:  state_d = last_bfly ? S_UNLOAD : S_ISSUE;
         S_UNLOAD: if (i_out_ready && (cnt_q == 4'd15)) state_d = S_LOAD;
         default:  state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_LOAD;
         cnt_q        <= 4'd0;
         s_q          <= 2'd0;
         b_q          <= 3'd0;
         armed_q      <= 1'b0;
         frame_done_q <= 1'b0;
         in0_re_q     <= '0;
         in0_im_q     <= '0;
         in1_re_q     <= '0;
         in1_im_q     <= '0;
         tw_re_q      <= '0;
         tw_im_q      <= '0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= 1'b0;
         case (state_q)
            S_LOAD: begin
               if (i_in_valid) cnt_q <= cnt_q + 4'd1;
               s_q <= 2'd0;
               b_q <= 3'd0;
            end
            S_ISSUE: begin
               in0_re_q <= mem_re[top_addr];
               in0_im_q <= mem_im[top_addr];
               in1_re_q <= mem_re[bot_addr];
               in1_im_q <= mem_im[bot_addr];
               tw_re_q  <= rom_re;
               tw_im_q  <= rom_im;
               armed_q  <= 1'b0;
            end
            S_WAIT: begin
               // A done level left over from the previous butterfly must drop first.
               if (!i_bf_done) armed_q <= 1'b1;
            end
            S_WRITE: begin
               if (b_q != 3'd7) begin
                  b_q <= b_q + 3'd1;
               end else if (s_q != 2'd3) begin
                  s_q <= s_q + 2'd1;
                  b_q <= 3'd0;
               end else begin
                  s_q   <= 2'd0;
                  b_q   <= 3'd0;
                  cnt_q <= 4'd0;
               end
            end
            S_UNLOAD: begin
               if (i_out_ready) begin
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd15) frame_done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Register file carries no reset: every entry is rewritten by the next load.
   always_ff @(posedge i_clk) begin
      if (in_fire) begin
         mem_re[load_addr] <= i_in_re;
         mem_im[load_addr] <= i_in_im;
      end else if (state_q == S_WRITE) begin
         mem_re[top_addr] <= i_bf_out0_re;
         mem_im[top_addr] <= i_bf_out0_im;
         mem_re[bot_addr] <= i_bf_out1_re;
         mem_im[bot_addr] <= i_bf_out1_im;
      end
   end

   assign o_in_ready   = (state_q == S_LOAD);
   assign o_busy       = (state_q != S_LOAD);
   assign o_out_valid  = (state_q == S_UNLOAD);
   assign o_out_re     = (state_q == S_UNLOAD) ? mem_re[cnt_q] : '0;
   assign o_out_im     = (state_q == S_UNLOAD) ? mem_im[cnt_q] : '0;
   assign o_out_idx    = (state_q == S_UNLOAD) ? cnt_q : 4'd0;
   assign o_frame_done = frame_done_q;
   assign o_dbg_state  = state_q;

   assign o_bf_in0_re  = in0_re_q;
   assign o_bf_in0_im  = in0_im_q;
   assign o_bf_in1_re  = in1_re_q;
   assign o_bf_in1_im  = in1_im_q;
   assign o_bf_tw_re   = tw_re_q;
   assign o_bf_tw_im   = tw_im_q;

   logic unused_ok;
   assign unused_ok = out_fire;

endmodule
